// File: rtl/keccak_absorb_buffer.sv
// rtl/keccak_absorb_buffer.sv - Keccak rate-block absorb buffer with SHA3/SHAKE padding
module keccak_absorb_buffer #(
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DOMAIN     = 8'h06
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [63:0]                din,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic                       din_last,
    input  logic [3:0]                 din_bytes,
    output logic [RATE_LANES*64-1:0]   blk_data,
    output logic                       blk_valid,
    input  logic                       blk_ready,
    output logic                       blk_last
);

    localparam int            CW        = $clog2(RATE_LANES);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATE_LANES - 1);

    typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pad_q, pad_d;
    logic          last_q, last_d;
    logic [63:0]   lane_q [RATE_LANES];
    logic [63:0]   lane_d [RATE_LANES];

    logic          at_end;
    logic [3:0]    nbytes;
    logic [5:0]    shamt;
    logic [63:0]   keep_mask;
    logic [63:0]   dom_word;

    assign at_end    = (cnt_q == LAST_LANE);
    assign nbytes    = (din_bytes > 4'd8) ? 4'd8 : din_bytes;
    assign shamt     = {nbytes[2:0], 3'b000};
    assign keep_mask = nbytes[3] ? '1 : ((64'd1 << shamt) - 64'd1);
    assign dom_word  = {56'd0, DOMAIN};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
            lane_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (din_valid && (din_last || at_end)) state_d = HOLD;
            PAD:     state_d = HOLD;
            HOLD:    if (blk_ready) state_d = pad_q ? PAD : FILL;
            default: state_d = FILL;
        endcase
    end

    // Block assembly: data lanes, domain byte and the final 0x80 bit of the rate
    always_comb begin
        lane_d = lane_q;
        cnt_d  = cnt_q;
        pad_d  = pad_q;
        last_d = last_q;
        case (state_q)
            FILL: begin
                if (din_valid) begin
                    if (!din_last) begin
                        lane_d[cnt_q] = din;
                        cnt_d         = at_end ? '0 : cnt_q + CW'(1);
                    end else begin
                        cnt_d = '0;
                        if (!nbytes[3]) begin
                            lane_d[cnt_q] = (din & keep_mask) | (dom_word << shamt);
                            lane_d[RATE_LANES-1][63:56] = lane_d[RATE_LANES-1][63:56] | 8'h80;
                            last_d = 1'b1;
                        end else if (!at_end) begin
                            lane_d[cnt_q]          = din;
                            lane_d[cnt_q + CW'(1)] = dom_word;
                            lane_d[RATE_LANES-1][63:56] = lane_d[RATE_LANES-1][63:56] | 8'h80;
                            last_d = 1'b1;
                        end else begin
                            // Full final lane: padding spills into an extra block
                            lane_d[cnt_q] = din;
                            last_d        = 1'b0;
                            pad_d         = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                lane_d[0] = dom_word;
                lane_d[RATE_LANES-1][63:56] = lane_d[RATE_LANES-1][63:56] | 8'h80;
                pad_d  = 1'b0;
                last_d = 1'b1;
            end
            HOLD: begin
                if (blk_ready) begin
                    lane_d = '{default: '0};
                    cnt_d  = '0;
                    last_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        din_ready = (state_q == FILL);
        blk_valid = (state_q == HOLD);
        blk_last  = last_q;
        blk_data  = '0;
        for (int i = 0; i < RATE_LANES; i++) begin
            blk_data[64*i +: 64] = lane_q[i];
        end
    end

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// tb/tb_keccak_absorb_buffer.sv - randomized bench for keccak_absorb_buffer against a byte-level padding model
module tb_keccak_absorb_buffer;

    localparam int         R     = 17;
    localparam int         RB    = R * 8;
    localparam int         W     = R * 64;
    localparam logic [7:0] DOM   = 8'h06;
    localparam int         N_MSG = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          din_last = 1'b0;
    logic [3:0]    din_bytes = '0;
    logic [W-1:0]  blk_data;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic          blk_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0]  mw[$];
    int           mlb;
    logic [W-1:0] exp_data[$];
    bit           exp_last[$];
    bit           drv_done = 1'b0;

    int dir_len [6] = '{1, 18, 17, 17, 3, 5};
    int dir_lb  [6] = '{0, 0, 8, 7, 8, 13};

    keccak_absorb_buffer #(.RATE_LANES(R), .DOMAIN(DOM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_last  (din_last),
        .din_bytes (din_bytes),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Message as a byte string, padded as SHA3 pad10*1 with the domain byte, cut into rate blocks
    task automatic model_expect();
        logic [7:0]   bq[$];
        logic [W-1:0] blk;
        int           nb, plen, nblk;
        for (int i = 0; i < mw.size() - 1; i++)
            for (int b = 0; b < 8; b++) bq.push_back(mw[i][8*b +: 8]);
        nb = (mlb > 8) ? 8 : mlb;
        for (int b = 0; b < nb; b++) bq.push_back(mw[mw.size()-1][8*b +: 8]);
        plen = (bq.size() / RB + 1) * RB;
        bq.push_back(DOM);
        while (bq.size() < plen) bq.push_back(8'h00);
        bq[plen-1] = bq[plen-1] | 8'h80;
        nblk = plen / RB;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < RB; j++) blk[8*j +: 8] = bq[k*RB + j];
            exp_data.push_back(blk);
            exp_last.push_back(k == nblk - 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_blk_valid", {63'd0, blk_valid}, 64'd0);
        check("rst_blk_last", {63'd0, blk_last}, 64'd0);
        check("rst_blk_data_or", {63'd0, |blk_data}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("din_ready_after_rst", {63'd0, din_ready}, 64'd1);

        for (int k = 0; k < 5; k++) begin
            din = {$urandom, $urandom} | 64'h1;
            din_valid = 1'b1;
            din_last = 1'b0;
            @(negedge clk);
        end
        din_valid = 1'b0;
        check("partial_data_present", {63'd0, |blk_data}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_blk_valid", {63'd0, blk_valid}, 64'd0);
        check("async_rst_blk_last", {63'd0, blk_last}, 64'd0);
        check("async_rst_blk_data_or", {63'd0, |blk_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("din_ready_after_rst2", {63'd0, din_ready}, 64'd1);

        fork
            begin : drv
                bit lat_pending;
                int len, lb, i;
                lat_pending = 1'b0;
                for (int m = 0; m < N_MSG; m++) begin
                    if (m < 6) begin
                        len = dir_len[m];
                        lb  = dir_lb[m];
                    end else begin
                        len = $urandom_range(1, 40);
                        lb  = $urandom_range(0, 15);
                    end
                    mw.delete();
                    for (int k = 0; k < len; k++) mw.push_back(m == 1 ? 64'(k) : {$urandom, $urandom});
                    mlb = lb;
                    model_expect();
                    i = 0;
                    while (i < len) begin
                        @(negedge clk);
                        if (lat_pending) begin
                            check("blk_latency", {63'd0, blk_valid}, 64'd1);
                            lat_pending = 1'b0;
                        end
                        if ($urandom_range(0, 3) == 0) begin
                            din_valid = 1'b0;
                            din = {$urandom, $urandom};
                        end else begin
                            din = mw[i];
                            din_valid = 1'b1;
                            din_last = (i == len - 1);
                            din_bytes = 4'(lb);
                            if (din_ready) begin
                                lat_pending = din_last || (i % R == R - 1);
                                i++;
                            end
                        end
                    end
                end
                @(negedge clk);
                din_valid = 1'b0;
                if (lat_pending) check("blk_latency", {63'd0, blk_valid}, 64'd1);
                drv_done = 1'b1;
            end
            begin : cons
                logic [W-1:0] held;
                logic         held_last;
                bit           have;
                int           stall, nseen;
                have = 1'b0;
                stall = 0;
                nseen = 0;
                while (!drv_done || exp_data.size() > 0) begin
                    @(negedge clk);
                    if (blk_valid) begin
                        check("ready_while_valid", {63'd0, din_ready}, 64'd0);
                        if (!have) begin
                            if (exp_data.size() == 0) begin
                                check("unexpected_blk", 64'd1, 64'd0);
                            end else begin
                                for (int l = 0; l < R; l++)
                                    check($sformatf("blk%0d_lane%0d", nseen, l),
                                          blk_data[64*l +: 64], exp_data[0][64*l +: 64]);
                                check($sformatf("blk%0d_last", nseen), {63'd0, blk_last}, {63'd0, exp_last[0]});
                            end
                            held = blk_data;
                            held_last = blk_last;
                            have = 1'b1;
                            stall = (nseen == 0 || $urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 2);
                        end else begin
                            check("hold_stable", {62'd0, blk_last !== held_last, blk_data !== held}, 64'd0);
                        end
                        if (stall == 0) begin
                            blk_ready = 1'b1;
                            have = 1'b0;
                            nseen++;
                            if (exp_data.size() > 0) begin
                                void'(exp_data.pop_front());
                                void'(exp_last.pop_front());
                            end
                        end else begin
                            blk_ready = 1'b0;
                            stall--;
                        end
                    end else begin
                        blk_ready = 1'($urandom_range(0, 1));
                    end
                end
                @(negedge clk);
                blk_ready = 1'b0;
                check("no_extra_blk", {63'd0, blk_valid}, 64'd0);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_buffer.md
KECCAK_ABSORB_BUFFER -- requirements
Module: keccak_absorb_buffer

Interface
REQ-001 Parameter RATE_LANES, default 17, is the rate in 64-bit lanes (17 = 1088 bits, SHA3-256); legal range 2..24.
REQ-002 Parameter DOMAIN, default 8'h06, is the domain-separation byte (SHA3 = 06, SHAKE = 1F).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 din  in  64  message word; byte k = din[8k+7:8k], little-endian lane order.
REQ-006 din_valid  in  1  din, din_last and din_bytes are valid.
REQ-007 din_ready  out  1  buffer accepts a word this cycle.
REQ-008 din_last  in  1  final word of the message.
REQ-009 din_bytes  in  4  count of valid bytes in the last word, 0..8; ignored unless din_last=1; values above 8 are treated as 8.
REQ-010 blk_data  out  RATE_LANES*64  padded rate block; lane i = blk_data[64i+63:64i]; feeds the permutation XOR stage.
REQ-011 blk_valid  out  1  blk_data is a complete block.
REQ-012 blk_ready  in  1  downstream consumes the block.
REQ-013 blk_last  out  1  the presented block is the final block of the message.

Function
REQ-014 FSM states: FILL, PAD, HOLD; din_ready = (state==FILL); blk_valid = (state==HOLD).
REQ-015 FILL: a transfer occurs on din_valid & din_ready; a non-last word is written to lane cnt, and cnt increments.
REQ-016 A non-last word written to lane RATE_LANES-1 -> HOLD next cycle, blk_last=0, cnt=0.
REQ-017 A last word at lane cnt: bytes 0..din_bytes-1 come from din; the remaining bytes of that lane are zero.
REQ-018 Last word with din_bytes<8: DOMAIN goes to byte din_bytes of lane cnt; byte 7 of lane RATE_LANES-1 is ORed with 8'h80; when both land on the same byte the value is DOMAIN|8'h80 (86 for SHA3); -> HOLD, blk_last=1.
REQ-019 Last word with din_bytes=8 and cnt<RATE_LANES-1: DOMAIN goes to byte 0 of lane cnt+1; 8'h80 is ORed into lane RATE_LANES-1 byte 7; -> HOLD, blk_last=1.
REQ-020 Last word with din_bytes=8 and cnt=RATE_LANES-1: the block is full; -> HOLD with blk_last=0 and the pad_pending flag set.
REQ-021 Lanes not written before the last word read as zero.
REQ-022 Latency: blk_valid rises on the cycle after the beat that completes the block.
REQ-023 HOLD: blk_data, blk_valid and blk_last are stable until blk_ready=1. On the handshake the whole buffer clears to zero, cnt=0, and the next state is PAD if pad_pending is set, otherwise FILL.
REQ-024 PAD: lasts exactly 1 cycle; writes lane0 = DOMAIN and lane RATE_LANES-1 byte 7 = 8'h80, all else zero; clears pad_pending; -> HOLD with blk_last=1.
REQ-025 din is not accepted in HOLD or PAD; din_valid held high there has no effect.
REQ-026 blk_ready while blk_valid=0 is ignored.
REQ-027 After a blk_last=1 handshake, the next message starts in FILL at lane 0; there are no idle cycles beyond the HOLD->FILL edge.
REQ-028 cnt width is clog2(RATE_LANES); cnt never exceeds RATE_LANES-1.

Reset
REQ-029 rst_n low: immediately state=FILL, cnt=0, pad_pending=0, buffer all zero, blk_valid=0, blk_last=0, blk_data=0.
REQ-030 din_ready=1 from the first rising edge after rst_n deasserts.
REQ-031 Reset mid-block or in HOLD discards all partial data; no block is emitted for it.

Verification
REQ-032 Empty message: a single beat din_last=1, din_bytes=0 -> one block; lane0=0x06, lane16=0x8000000000000000, other lanes 0, blk_last=1.
REQ-033 17 full words 0..16 followed by a last beat with din_bytes=0 -> block 1: lane i=i, blk_last=0; block 2: lane0=0x06, lane16 byte7=0x80, blk_last=1.
REQ-034 Exactly 17 words, the last with din_bytes=8 -> full data block (blk_last=0), one PAD cycle, then a pad-only block (blk_last=1).
REQ-035 16 words plus a last beat with din_bytes=7 -> lane16 = {0x86, data bytes 6..0}, blk_last=1.
REQ-036 Hold blk_ready=0 for 10 cycles while din_valid=1 -> blk_data is stable, din_ready=0, and no word is lost once blk_ready=1.
REQ-037 Assert rst_n=0 after 5 words -> all outputs are 0 asynchronously; a subsequent empty message produces the REQ-032 block.
